// File: rtl/axis_buf_pkg.sv
// Shared types for the AXI-Stream packet buffer: beat layout and release-FSM states.
package axis_buf_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] tdata;
        logic [STRB_WIDTH-1:0] tstrb;
        logic                  tlast;
    } axis_beat_t;

    typedef enum logic {
        HOLD   = 1'b0,
        STREAM = 1'b1
    } rel_state_t;

    // Storage bits per beat: data, byte strobes and the last flag.
    function automatic int beat_bits(input int dw);
        return dw + dw / 8 + 1;
    endfunction

endpackage

// File: rtl/axis_buf_ram.sv
// Simple dual-port register array: one synchronous write port, one asynchronous read port.
module axis_buf_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 37
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_packet_buffer.sv
// AXI-Stream FIFO with registered first-word-fall-through head; optionally releases
// only complete packets, with a forced release when a packet cannot fit.
module axis_packet_buffer #(
    parameter int DATA_WIDTH        = 32,
    parameter int DEPTH             = 16,
    parameter bit STORE_AND_FORWARD = 1'b1
) (
    input  logic                       axis_aclk,
    input  logic                       axis_aresetn,
    input  logic [DATA_WIDTH-1:0]      s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]    s01_axis_tstrb,
    input  logic                       s01_axis_tvalid,
    input  logic                       s01_axis_tlast,
    output logic                       s01_axis_tready,
    input  logic                       m01_axis_tready,
    output logic [DATA_WIDTH-1:0]      m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]    m01_axis_tstrb,
    output logic                       m01_axis_tvalid,
    output logic                       m01_axis_tlast,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [$clog2(DEPTH):0]     pkt_count,
    output logic                       overrun
);

    import axis_buf_pkg::rel_state_t;
    import axis_buf_pkg::HOLD;
    import axis_buf_pkg::STREAM;
    import axis_buf_pkg::beat_bits;

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = beat_bits(DATA_WIDTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      occ_q, occ_d;
    logic [CNT_W-1:0]      pkt_q, pkt_d;
    logic                  overrun_q, overrun_d;
    logic                  head_vld_q, head_vld_d;
    logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
    logic [STRB_W-1:0]     head_strb_q, head_strb_d;
    logic                  head_last_q, head_last_d;
    rel_state_t            state_q, state_d;

    logic                  wr_en;
    logic                  rd_en;
    logic                  wr_last;
    logic                  rd_last;
    logic                  head_load;
    logic                  forced_rel;
    logic [BEAT_W-1:0]     wr_beat;
    logic [BEAT_W-1:0]     rd_beat;

    // Handshakes: a beat moves when valid and ready are both high at a rising edge;
    // once m01_axis_tvalid rises, the head beat is held unchanged until accepted.
    assign s01_axis_tready = (occ_q != FULL_CNT);
    assign wr_en           = s01_axis_tvalid && s01_axis_tready;
    assign rd_en           = m01_axis_tvalid && m01_axis_tready;
    assign wr_last         = wr_en && s01_axis_tlast;
    assign rd_last         = rd_en && head_last_q;
    assign wr_beat         = {s01_axis_tdata, s01_axis_tstrb, s01_axis_tlast};

    axis_buf_ram #(
        .DEPTH (DEPTH),
        .WIDTH (BEAT_W)
    ) u_ram (
        .clk_i   (axis_aclk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_beat),
        .raddr_i (rd_ptr_d),
        .rdata_o (rd_beat)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);

        occ_d = occ_q;
        if (wr_en && !rd_en) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (!wr_en && rd_en) begin
            occ_d = occ_q - CNT_W'(1);
        end

        pkt_d = pkt_q;
        if (wr_last && !rd_last) begin
            pkt_d = pkt_q + CNT_W'(1);
        end else if (!wr_last && rd_last) begin
            pkt_d = pkt_q - CNT_W'(1);
        end
    end

    // The head entry stays counted in occupancy; refill it only from beats already in the RAM.
    always_comb begin
        head_vld_d  = head_vld_q;
        head_data_d = head_data_q;
        head_strb_d = head_strb_q;
        head_last_d = head_last_q;
        head_load   = (rd_en || !head_vld_q) &&
                      (occ_q > (rd_en ? CNT_W'(1) : CNT_W'(0)));
        if (head_load) begin
            head_vld_d = 1'b1;
            {head_data_d, head_strb_d, head_last_d} = rd_beat;
        end else if (rd_en) begin
            head_vld_d = 1'b0;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            pkt_q       <= '0;
            overrun_q   <= 1'b0;
            head_vld_q  <= 1'b0;
            head_data_q <= '0;
            head_strb_q <= '0;
            head_last_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            pkt_q       <= pkt_d;
            overrun_q   <= overrun_d;
            head_vld_q  <= head_vld_d;
            head_data_q <= head_data_d;
            head_strb_q <= head_strb_d;
            head_last_q <= head_last_d;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            state_q <= STORE_AND_FORWARD ? HOLD : STREAM;
        end else begin
            state_q <= state_d;
        end
    end

    // A full buffer with no complete packet would deadlock, so its packet is released early.
    always_comb begin
        state_d    = state_q;
        forced_rel = 1'b0;
        if (!STORE_AND_FORWARD) begin
            state_d = STREAM;
        end else begin
            case (state_q)
                HOLD: begin
                    if (pkt_q != '0) begin
                        state_d = STREAM;
                    end else if (occ_q == FULL_CNT) begin
                        state_d    = STREAM;
                        forced_rel = 1'b1;
                    end
                end
                STREAM: begin
                    if (rd_last && (pkt_d == '0)) begin
                        state_d = HOLD;
                    end
                end
                default: state_d = HOLD;
            endcase
        end
        overrun_d = overrun_q | forced_rel;
    end

    always_comb begin
        m01_axis_tvalid = head_vld_q && (state_q == STREAM);
    end

    assign m01_axis_tdata = head_data_q;
    assign m01_axis_tstrb = head_strb_q;
    assign m01_axis_tlast = head_last_q;
    assign occupancy      = occ_q;
    assign pkt_count      = pkt_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_axis_packet_buffer.sv
// Directed bench for axis_packet_buffer: cut-through and store-and-forward instances.
module tb_axis_packet_buffer;

    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int BW    = DW + SW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    // Cut-through instance
    logic [DW-1:0] c_data, c_m_data;
    logic [SW-1:0] c_strb, c_m_strb;
    logic          c_valid, c_last, c_s_ready, c_m_ready, c_m_valid, c_m_last, c_ovr;
    logic [CW-1:0] c_occ, c_pkt;

    // Store-and-forward instance
    logic [DW-1:0] s_data, s_m_data;
    logic [SW-1:0] s_strb, s_m_strb;
    logic          s_valid, s_last, s_ready, s_m_ready, s_m_valid, s_m_last, s_ovr;
    logic [CW-1:0] s_occ, s_pkt;

    axis_packet_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STORE_AND_FORWARD(1'b0)) dut_ct (
        .axis_aclk(clk), .axis_aresetn(rstn),
        .s01_axis_tdata(c_data), .s01_axis_tstrb(c_strb), .s01_axis_tvalid(c_valid),
        .s01_axis_tlast(c_last), .s01_axis_tready(c_s_ready),
        .m01_axis_tready(c_m_ready), .m01_axis_tdata(c_m_data), .m01_axis_tstrb(c_m_strb),
        .m01_axis_tvalid(c_m_valid), .m01_axis_tlast(c_m_last),
        .occupancy(c_occ), .pkt_count(c_pkt), .overrun(c_ovr)
    );

    axis_packet_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STORE_AND_FORWARD(1'b1)) dut_sf (
        .axis_aclk(clk), .axis_aresetn(rstn),
        .s01_axis_tdata(s_data), .s01_axis_tstrb(s_strb), .s01_axis_tvalid(s_valid),
        .s01_axis_tlast(s_last), .s01_axis_tready(s_ready),
        .m01_axis_tready(s_m_ready), .m01_axis_tdata(s_m_data), .m01_axis_tstrb(s_m_strb),
        .m01_axis_tvalid(s_m_valid), .m01_axis_tlast(s_m_last),
        .occupancy(s_occ), .pkt_count(s_pkt), .overrun(s_ovr)
    );

    int total = 0;
    int bad   = 0;
    int reads = 0;
    int max_occ;
    logic [BW-1:0] src_q[$];
    logic [BW-1:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Beat encoding {last, strb, data}; strobes follow the low data nibble.
    function automatic logic [BW-1:0] mk(input logic [DW-1:0] d, input logic l);
        return {l, d[SW-1:0], d};
    endfunction

    task automatic offer(input logic [BW-1:0] b);
        src_q.push_back(b);
        exp_q.push_back(b);
    endtask

    // Drives queued beats into dut_sf and checks every accepted output beat in order.
    task automatic pump(input int cycles, input logic sink_rdy, input bit until_done);
        int n = 0;
        s_m_ready = sink_rdy;
        while (n < cycles && !(until_done && src_q.size() == 0 && exp_q.size() == 0)) begin
            s_valid = (src_q.size() != 0);
            if (s_valid) {s_last, s_strb, s_data} = src_q[0];
            if (s_m_valid && s_m_ready) begin
                reads++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL beat_extra observed=%0h expected=none", {s_m_last, s_m_strb, s_m_data});
                end else begin
                    check("beat", {s_m_last, s_m_strb, s_m_data}, exp_q.pop_front());
                end
            end
            if (s_valid && s_ready) void'(src_q.pop_front());
            tick();
            n++;
        end
        s_valid = 1'b0;
        if (until_done) check("drain_done", src_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        rstn = 1'b0;
        c_valid = 0; c_data = '0; c_strb = '0; c_last = 0; c_m_ready = 0;
        s_valid = 0; s_data = '0; s_strb = '0; s_last = 0; s_m_ready = 0;
        tick();
        tick();
        rstn = 1'b1;

        // Reset values
        check("rst_occ", s_occ, 0);
        check("rst_pkt", s_pkt, 0);
        check("rst_ovr", s_ovr, 0);
        check("rst_mvalid", s_m_valid, 0);
        check("rst_mdata", {s_m_last, s_m_strb, s_m_data}, 0);
        check("rst_sready", s_ready, 1);
        check("rst_ct_mvalid", c_m_valid, 0);
        check("rst_ct_sready", c_s_ready, 1);

        // Cut-through, one beat every other cycle, sink always ready
        c_m_ready = 1'b1;
        max_occ = 0;
        for (int i = 0; i < 4; i++) begin
            c_valid = 1'b1; c_data = 32'hA0 + i; c_strb = 4'hF; c_last = (i == 3);
            tick();
            c_valid = 1'b0;
            if (c_occ > max_occ) max_occ = c_occ;
            check("ct_gap_valid", c_m_valid, 0);
            tick();
            if (c_occ > max_occ) max_occ = c_occ;
            check("ct_valid", c_m_valid, 1);
            check("ct_data", c_m_data, 32'hA0 + i);
            check("ct_last", c_m_last, (i == 3) ? 1 : 0);
        end
        tick();
        check("ct_end_occ", c_occ, 0);
        check("ct_end_valid", c_m_valid, 0);
        check("ct_end_pkt", c_pkt, 0);
        check("ct_peak_occ", max_occ, 1);
        c_m_ready = 1'b0;

        // Store-and-forward, 3-beat packet, sink ready
        s_m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            {s_last, s_strb, s_data} = mk(32'hB0 + i, i == 2);
            tick();
            check("sf_hold_valid", s_m_valid, 0);
            check("sf_pkt_in", s_pkt, (i == 2) ? 1 : 0);
        end
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sf_valid", s_m_valid, 1);
            check("sf_beat", {s_m_last, s_m_strb, s_m_data}, mk(32'hB0 + i, i == 2));
            check("sf_pkt_out", s_pkt, 1);
        end
        tick();
        check("sf_end_valid", s_m_valid, 0);
        check("sf_end_pkt", s_pkt, 0);
        check("sf_end_occ", s_occ, 0);
        s_m_ready = 1'b0;

        // Full buffer: 20 single-beat packets against a stalled sink
        reads = 0;
        for (int i = 0; i < 20; i++) offer(mk(32'hC0 + i, 1'b1));
        pump(20, 1'b0, 1'b0);
        check("full_sready", s_ready, 0);
        check("full_occ", s_occ, 16);
        check("full_pkt", s_pkt, 16);
        check("full_left", src_q.size(), 4);
        check("full_mvalid", s_m_valid, 1);
        // One read frees a slot; the offered beat is not taken on that same edge
        s_m_ready = 1'b1;
        s_valid = 1'b1;
        {s_last, s_strb, s_data} = src_q[0];
        check("full_head", {s_m_last, s_m_strb, s_m_data}, exp_q.pop_front());
        reads++;
        tick();
        check("full_read_occ", s_occ, 15);
        check("full_read_sready", s_ready, 1);
        pump(100, 1'b1, 1'b1);
        check("full_reads", reads, 20);
        check("full_end_occ", s_occ, 0);
        check("full_end_pkt", s_pkt, 0);
        check("full_no_ovr", s_ovr, 0);

        // Forced release: 18-beat packet into 16 entries
        reads = 0;
        for (int i = 0; i < 18; i++) offer(mk(32'hD0 + i, i == 17));
        pump(20, 1'b0, 1'b0);
        check("force_occ", s_occ, 16);
        check("force_pkt", s_pkt, 0);
        check("force_ovr", s_ovr, 1);
        check("force_mvalid", s_m_valid, 1);
        pump(100, 1'b1, 1'b1);
        check("force_reads", reads, 18);
        check("force_ovr_sticky", s_ovr, 1);
        check("force_end_pkt", s_pkt, 0);
        check("force_end_valid", s_m_valid, 0);

        // Concurrent write+read at occupancy 5 across pointer wrap
        for (int i = 0; i < 5; i++) offer(mk(32'hE0 + i, 1'b1));
        pump(5, 1'b0, 1'b0);
        check("wrap_fill_occ", s_occ, 5);
        for (int i = 0; i < 10; i++) begin
            offer(mk(32'hE5 + i, 1'b1));
            pump(1, 1'b1, 1'b0);
            check("wrap_occ", s_occ, 5);
        end
        pump(50, 1'b1, 1'b1);
        check("wrap_end_occ", s_occ, 0);

        // Reset in the middle of a partial packet
        for (int i = 0; i < 3; i++) offer(mk(32'hF0 + i, 1'b0));
        pump(3, 1'b1, 1'b0);
        check("mid_occ", s_occ, 3);
        check("mid_hold", s_m_valid, 0);
        src_q.delete();
        exp_q.delete();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("mrst_occ", s_occ, 0);
        check("mrst_pkt", s_pkt, 0);
        check("mrst_ovr", s_ovr, 0);
        check("mrst_mvalid", s_m_valid, 0);
        check("mrst_sready", s_ready, 1);
        check("mrst_mdata", {s_m_last, s_m_strb, s_m_data}, 0);
        reads = 0;
        offer(mk(32'h55, 1'b1));
        pump(20, 1'b1, 1'b1);
        check("mrst_reads", reads, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
